// File: rtl/xadc_sample_framer.sv
// Reads each enabled XADC conversion result over DRP and streams it out as a
// 4-byte frame {sync, channel, seq/sample[11:8], sample[7:0]} on an 8-bit AXI-Stream.
module xadc_sample_framer #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [31:0] CH_ENABLE_MASK = 32'h1010_0000,
    parameter int unsigned DRP_TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eoc,
    input  logic [4:0]  channel,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [6:0]  drp_daddr,
    output logic [15:0] drp_di,
    input  logic        drp_drdy,
    input  logic [15:0] drp_do,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [15:0] drop_count,
    output logic [7:0]  timeout_count
);

    localparam int unsigned TW = (DRP_TIMEOUT > 1) ? $clog2(DRP_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRP_REQ  = 2'd1,
        S_DRP_WAIT = 2'd2,
        S_SEND     = 2'd3
    } state_t;

    state_t          r_state;
    logic [4:0]      r_ch;
    logic [11:0]     r_sample;
    logic [3:0]      r_seq;
    logic [1:0]      r_idx;
    logic [TW-1:0]   r_wait_cnt;
    logic            r_den;
    logic [6:0]      r_daddr;
    logic [7:0]      r_tdata;
    logic            r_tvalid;
    logic [15:0]     r_drop;
    logic [7:0]      r_tmo;

    logic            w_ch_en;
    logic            w_busy_drop;
    logic            w_xfer;
    logic [7:0]      w_next_byte;
    logic            w_unused_ok;

    assign w_ch_en     = CH_ENABLE_MASK[channel];
    assign w_busy_drop = eoc && w_ch_en && (r_state != S_IDLE);
    assign w_xfer      = r_tvalid && m_tready;
    // The DRP result occupies the top 12 bits; the low nibble is discarded.
    assign w_unused_ok = ^drp_do[3:0];

    // Byte presented after the one at r_idx transfers.
    always_comb begin
        w_next_byte = 8'h00;
        case (r_idx)
            2'd0:    w_next_byte = {3'b000, r_ch};
            2'd1:    w_next_byte = {r_seq, r_sample[11:8]};
            2'd2:    w_next_byte = r_sample[7:0];
            default: w_next_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ch       <= 5'd0;
            r_sample   <= 12'd0;
            r_seq      <= 4'd0;
            r_idx      <= 2'd0;
            r_wait_cnt <= '0;
            r_den      <= 1'b0;
            r_daddr    <= 7'd0;
            r_tdata    <= 8'h00;
            r_tvalid   <= 1'b0;
            r_drop     <= 16'd0;
            r_tmo      <= 8'd0;
        end else begin
            r_den <= 1'b0;
            // Any enabled eoc arriving outside IDLE is lost; count it.
            if (w_busy_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (eoc && w_ch_en) begin
                        r_ch    <= channel;
                        r_daddr <= {2'b00, channel};
                        r_den   <= 1'b1;
                        r_state <= S_DRP_REQ;
                    end
                end
                S_DRP_REQ: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_DRP_WAIT;
                end
                S_DRP_WAIT: begin
                    if (drp_drdy) begin
                        r_sample <= drp_do[15:4];
                        r_idx    <= 2'd0;
                        r_tdata  <= SYNC_BYTE;
                        r_tvalid <= 1'b1;
                        r_state  <= S_SEND;
                    end else if (r_wait_cnt == TW'(DRP_TIMEOUT - 1)) begin
                        if (r_tmo != 8'hFF) begin
                            r_tmo <= r_tmo + 8'd1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (r_idx == 2'd3) begin
                            r_tvalid <= 1'b0;
                            r_seq    <= r_seq + 4'd1;
                            r_state  <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 2'd1;
                            r_tdata <= w_next_byte;
                        end
                    end
                end
                default: begin
                    r_tvalid <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign drp_den       = r_den;
    assign drp_dwe       = 1'b0;
    assign drp_daddr     = r_daddr;
    assign drp_di        = 16'h0000;
    assign m_tdata       = r_tdata;
    assign m_tvalid      = r_tvalid;
    assign drop_count    = r_drop;
    assign timeout_count = r_tmo;

endmodule

// File: tb/tb_xadc_sample_framer.sv
// Bench for xadc_sample_framer: DRP responder, stream sink with selectable
// backpressure, and a frame model built from channel, DRP word and sequence count.
module tb_xadc_sample_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        eoc;
    logic [4:0]  channel;
    logic        drp_den;
    logic        drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic        drp_drdy;
    logic [15:0] drp_do;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [15:0] drop_count;
    logic [7:0]  timeout_count;

    xadc_sample_framer dut (
        .clk(clk), .rst(rst), .eoc(eoc), .channel(channel),
        .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
        .drp_drdy(drp_drdy), .drp_do(drp_do),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .drop_count(drop_count), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int tr_mode = 0;   // 0 ready, 1 toggle, 2 random, 3 stalled
    int cyc_n   = 0;
    int den_cnt = 0, den_long = 0, tv_cnt = 0, stall_err = 0;
    int mdl_seq = 0;
    logic [7:0] got_q[$];
    int         xfer_q[$];
    logic       prev_stall = 1'b0, prev_rst = 1'b0, prev_den = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [6:0] den_addr;
    logic       stall_tv;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(posedge clk) begin
        #1;
        case (tr_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            2:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
    end

    // Stream/DRP observer; a reset edge takes priority over a pending transfer.
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            got_q.push_back(m_tdata);
            xfer_q.push_back(cyc_n);
        end
        if (prev_stall && !prev_rst && !rst && (!m_tvalid || m_tdata !== prev_data)) stall_err++;
        if (drp_den) den_cnt++;
        if (drp_den && prev_den) den_long++;
        if (m_tvalid) tv_cnt++;
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_rst   = rst;
        prev_den   = drp_den;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    function automatic logic [31:0] model_frame(input int ch, input int data, input int seq);
        int sample, b2, b3;
        sample = data / 16;
        b2 = (seq % 16) * 16 + sample / 256;
        b3 = sample % 256;
        return {8'hA5, 8'(ch), 8'(b2), 8'(b3)};
    endfunction

    function automatic logic [31:0] got_frame();
        logic [31:0] f;
        f = 32'hxxxx_xxxx;
        if (got_q.size() >= 4) f = {got_q[0], got_q[1], got_q[2], got_q[3]};
        return f;
    endfunction

    function automatic logic [4:0] pick_en();
        return ($urandom_range(0, 1) != 0) ? 5'h14 : 5'h1C;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_eoc(input logic [4:0] ch);
        eoc = 1'b1;
        channel = ch;
        cyc();
        eoc = 1'b0;
        channel = 5'($urandom);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        mdl_seq = 0;
    endtask

    // Drives one eoc->DRP->stream sequence and collects the emitted bytes.
    task automatic run_frame(input logic [4:0] ch, input logic [15:0] data, input int delay,
                             input bit stall, input int inj_idx, input logic [4:0] inj_ch,
                             output bit ok);
        int n, saved;
        bit done, injected, stalled;
        ok = 1'b0; done = 1'b0; injected = 1'b0; stalled = 1'b0;
        stall_tv = 1'b0; den_addr = 7'h00;
        got_q.delete();
        xfer_q.delete();
        drive_eoc(ch);
        n = 0;
        while (!drp_den && n < 8) begin cyc(); n++; end
        if (!drp_den) return;
        den_addr = drp_daddr;
        repeat (delay) cyc();
        drp_drdy = 1'b1;
        drp_do = data;
        cyc();
        drp_drdy = 1'b0;
        drp_do = 16'($urandom);
        n = 0;
        while (!done && n < 400) begin
            if (inj_idx >= 0 && !injected && m_tvalid && got_q.size() == inj_idx) begin
                eoc = 1'b1;
                channel = inj_ch;
                injected = 1'b1;
            end
            if (stall && !stalled && got_q.size() == 2) begin
                saved = tr_mode;
                tr_mode = 3;
                repeat (11) cyc();
                stall_tv = m_tvalid;
                tr_mode = saved;
                stalled = 1'b1;
            end
            cyc();
            eoc = 1'b0;
            if (got_q.size() >= 4 && !m_tvalid) done = 1'b1;
            n++;
        end
        ok = done;
    endtask

    task automatic test_reset();
        logic [15:0] obs[8];
        string nm[8];
        rst = 1'b1; eoc = 1'b1; channel = 5'h14; drp_drdy = 1'b1;
        repeat (3) cyc();
        eoc = 1'b0; drp_drdy = 1'b0;
        obs[0] = 16'(drp_den);  nm[0] = "rst_den";
        obs[1] = 16'(drp_daddr); nm[1] = "rst_daddr";
        obs[2] = 16'(m_tvalid); nm[2] = "rst_tvalid";
        obs[3] = 16'(m_tdata);  nm[3] = "rst_tdata";
        obs[4] = drop_count;     nm[4] = "rst_drop";
        obs[5] = 16'(timeout_count); nm[5] = "rst_timeout";
        obs[6] = 16'(drp_dwe);  nm[6] = "rst_dwe";
        obs[7] = drp_di;         nm[7] = "rst_di";
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (obs[i] !== 16'h0000) $display("FAIL %s: got %h expected 0000", nm[i], obs[i]);
            else n_pass++;
        end
        rst = 1'b0;
        repeat (2) cyc();
        n_total++;
        if ({drp_den, m_tvalid} !== 2'b00) $display("FAIL post_reset_idle: got den/tvalid %b expected 00", {drp_den, m_tvalid});
        else n_pass++;
        mdl_seq = 0;
    endtask

    task automatic test_basic_frame();
        bit ok;
        int d0, dl;
        logic [31:0] gf;
        tr_mode = 0;
        cyc();
        d0 = den_cnt; dl = den_long;
        run_frame(5'h14, 16'hABC0, 3, 1'b0, -1, 5'h00, ok);
        repeat (3) cyc();
        gf = got_frame();
        n_total++;
        if (ok !== 1'b1) $display("FAIL basic_done: got %b expected 1", ok); else n_pass++;
        n_total++;
        if (den_cnt - d0 !== 1 || den_long !== dl) $display("FAIL basic_den_pulse: got %0d cycles expected 1", den_cnt - d0);
        else n_pass++;
        n_total++;
        if (den_addr !== 7'h14) $display("FAIL basic_daddr: got %h expected 14", den_addr); else n_pass++;
        n_total++;
        if (gf !== 32'hA514_0ABC) $display("FAIL basic_bytes: got %h expected a5140abc", gf); else n_pass++;
        n_total++;
        if (xfer_q.size() != 4 || xfer_q[3] - xfer_q[0] != 3)
            $display("FAIL basic_consecutive: got %0d transfers expected 4 in 4 cycles", xfer_q.size());
        else n_pass++;
        mdl_seq++;
    endtask

    task automatic test_backpressure();
        bit ok;
        int se;
        logic [4:0] ch;
        logic [15:0] data;
        logic [31:0] ef, gf;
        for (int f = 0; f < 5; f++) begin
            tr_mode = (f < 3) ? 1 : 2;
            ch = pick_en();
            data = 16'($urandom);
            se = stall_err;
            ef = model_frame(int'(ch), int'(data), mdl_seq);
            run_frame(ch, data, $urandom_range(1, 5), (f == 1 || f == 4), -1, 5'h00, ok);
            gf = got_frame();
            n_total++;
            if (ok !== 1'b1 || got_q.size() != 4) $display("FAIL bp_count: got %0d transfers expected 4", got_q.size());
            else n_pass++;
            n_total++;
            if (gf !== ef) $display("FAIL bp_bytes: got %h expected %h", gf, ef); else n_pass++;
            n_total++;
            if (stall_err !== se) $display("FAIL bp_stable: got %0d stall violations expected 0", stall_err - se);
            else n_pass++;
            if (f == 1 || f == 4) begin
                n_total++;
                if (stall_tv !== 1'b1) $display("FAIL bp_hold_valid: got tvalid %b expected 1", stall_tv);
                else n_pass++;
            end
            mdl_seq++;
        end
        tr_mode = 0;
    endtask

    task automatic test_filter_drops();
        bit ok;
        int d0;
        logic [15:0] drop0, data;
        logic [4:0] ch;
        logic [31:0] ef, gf;
        tr_mode = 0;
        cyc();
        drop0 = drop_count;
        d0 = den_cnt;
        drive_eoc(5'h03);
        for (int i = 0; i < 4; i++) begin
            do ch = 5'($urandom); while (ch == 5'h14 || ch == 5'h1C);
            drive_eoc(ch);
        end
        repeat (6) cyc();
        n_total++;
        if (den_cnt !== d0) $display("FAIL filt_no_den: got %0d den pulses expected 0", den_cnt - d0); else n_pass++;
        n_total++;
        if (drop_count !== drop0) $display("FAIL filt_drop_same: got %0d expected %0d", drop_count, drop0); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            data = 16'($urandom);
            ch = (k == 0) ? 5'h14 : 5'h1C;
            ef = model_frame(int'(ch), int'(data), mdl_seq);
            run_frame(ch, data, 2, 1'b0, (k == 0) ? 0 : 3, (k == 0) ? 5'h1C : 5'h14, ok);
            repeat (8) cyc();
            gf = got_frame();
            n_total++;
            if (drop_count !== 16'(drop0 + 16'(k + 1))) $display("FAIL drop_count_%0d: got %0d expected %0d", k, drop_count, drop0 + 16'(k + 1));
            else n_pass++;
            n_total++;
            if (den_cnt - d0 != k + 1 || got_q.size() != 4) $display("FAIL drop_one_frame_%0d: got %0d den %0d bytes expected %0d den 4 bytes", k, den_cnt - d0, got_q.size(), k + 1);
            else n_pass++;
            n_total++;
            if (ok !== 1'b1 || gf !== ef) $display("FAIL drop_bytes_%0d: got %h expected %h", k, gf, ef); else n_pass++;
            mdl_seq++;
        end
    endtask

    task automatic test_drp_timeout();
        bit ok;
        int n, tv0;
        logic [15:0] data;
        logic [31:0] ef, gf;
        tr_mode = 0;
        apply_reset();
        tv0 = tv_cnt;
        drive_eoc(5'h14);
        n = 0;
        while (!drp_den && n < 8) begin cyc(); n++; end
        n_total++;
        if (drp_den !== 1'b1) $display("FAIL tmo_den: got %b expected 1", drp_den); else n_pass++;
        repeat (64) cyc();
        n_total++;
        if (timeout_count !== 8'd0) $display("FAIL tmo_early: got %0d expected 0", timeout_count); else n_pass++;
        cyc();
        n_total++;
        if (timeout_count !== 8'd1) $display("FAIL tmo_count: got %0d expected 1", timeout_count); else n_pass++;
        n_total++;
        if (tv_cnt !== tv0) $display("FAIL tmo_no_valid: got %0d valid cycles expected 0", tv_cnt - tv0); else n_pass++;
        data = 16'($urandom);
        ef = model_frame(32'h1C, int'(data), 0);
        run_frame(5'h1C, data, 2, 1'b0, -1, 5'h00, ok);
        gf = got_frame();
        n_total++;
        if (ok !== 1'b1 || gf[15:12] !== 4'h0) $display("FAIL tmo_seq: got %h expected 0", gf[15:12]); else n_pass++;
        n_total++;
        if (gf !== ef) $display("FAIL tmo_next_frame: got %h expected %h", gf, ef); else n_pass++;
        mdl_seq = 1;
    endtask

    task automatic test_seq_wrap();
        bit ok;
        logic [4:0] ch;
        logic [15:0] data;
        logic [31:0] ef, gf;
        tr_mode = 0;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            ch = pick_en();
            data = 16'($urandom);
            ef = model_frame(int'(ch), int'(data), mdl_seq);
            run_frame(ch, data, $urandom_range(1, 4), 1'b0, -1, 5'h00, ok);
            gf = got_frame();
            n_total++;
            if (ok !== 1'b1 || gf[15:12] !== 4'(i % 16)) $display("FAIL wrap_seq_%0d: got %h expected %h", i, gf[15:12], 4'(i % 16));
            else n_pass++;
            n_total++;
            if (gf !== ef) $display("FAIL wrap_frame_%0d: got %h expected %h", i, gf, ef); else n_pass++;
            mdl_seq++;
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int n;
        logic [15:0] data;
        logic [31:0] ef, gf;
        tr_mode = 0;
        cyc();
        got_q.delete();
        drive_eoc(5'h14);
        n = 0;
        while (!drp_den && n < 8) begin cyc(); n++; end
        repeat (2) cyc();
        drp_drdy = 1'b1;
        drp_do = 16'($urandom);
        cyc();
        drp_drdy = 1'b0;
        n = 0;
        while (got_q.size() < 2 && n < 40) begin cyc(); n++; end
        n_total++;
        if (got_q.size() != 2) $display("FAIL rmf_reach_b1: got %0d bytes expected 2", got_q.size()); else n_pass++;
        rst = 1'b1;
        cyc();
        n_total++;
        if (m_tvalid !== 1'b0) $display("FAIL rmf_tvalid: got %b expected 0", m_tvalid); else n_pass++;
        cyc();
        rst = 1'b0;
        repeat (5) cyc();
        n_total++;
        if (got_q.size() != 2 || got_q[0] !== 8'hA5 || got_q[1] !== 8'h14 || m_tvalid !== 1'b0)
            $display("FAIL rmf_abandoned: got %0d bytes expected 2 (a5,14)", got_q.size());
        else n_pass++;
        mdl_seq = 0;
        data = 16'($urandom);
        ef = model_frame(32'h1C, int'(data), mdl_seq);
        run_frame(5'h1C, data, 3, 1'b0, -1, 5'h00, ok);
        gf = got_frame();
        n_total++;
        if (ok !== 1'b1 || gf[31:24] !== 8'hA5 || gf[15:12] !== 4'h0) $display("FAIL rmf_restart: got %h expected a5 with seq 0", gf);
        else n_pass++;
        n_total++;
        if (gf !== ef) $display("FAIL rmf_frame: got %h expected %h", gf, ef); else n_pass++;
        mdl_seq++;
    endtask

    initial begin
        rst = 1'b1;
        eoc = 1'b0;
        channel = 5'h00;
        drp_drdy = 1'b0;
        drp_do = 16'h0000;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_filter_drops();
        test_drp_timeout();
        test_seq_wrap();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/xadc_sample_framer.md
Name: xadc_sample_framer

Overview:
- Sits between the xadc_wiz_0 instance and the ft232h sys_axis sink.
- On each XADC end-of-conversion it reads the converted result over the DRP port.
- It formats the result into a fixed 4-byte frame and streams the frame byte-by-byte onto an 8-bit AXI-Stream source.
- Replaces the free-running test-byte generator in the XADC top level. Runs entirely in the sys_clk domain.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every frame.
- CH_ENABLE_MASK, 32'h1010_0000, bit n set = accept channel n (defaults: vaux4=0x14, vaux12=0x1C).
- DRP_TIMEOUT, 64, max cycles to wait for drdy after den before aborting.

Ports:
- clk  in  1  system clock (sys_clk)
- rst  in  1  synchronous active-high reset
- eoc  in  1  XADC eoc_out, single-cycle pulse
- channel  in  5  XADC channel_out, valid with eoc
- drp_den  out  1  DRP enable, single-cycle pulse
- drp_dwe  out  1  DRP write enable, tied 0
- drp_daddr  out  7  DRP address
- drp_di  out  16  DRP write data, tied 0
- drp_drdy  in  1  DRP read data valid
- drp_do  in  16  DRP read data; result is in [15:4]
- m_tdata  out  8  stream byte to FTDI sink
- m_tvalid  out  1  stream valid
- m_tready  in  1  stream ready
- drop_count  out  16  saturating count of eoc events lost because the block was busy
- timeout_count  out  8  saturating count of DRP timeouts

Behaviour:
- Reset values, all outputs: drp_den=0, drp_daddr=0, m_tvalid=0, m_tdata=0, drop_count=0, timeout_count=0. State=IDLE, seq=0.
- Reset mid-frame: the frame is abandoned and no further bytes are emitted; m_tvalid is 0 the cycle after rst is sampled.
- States: IDLE, DRP_REQ, DRP_WAIT, SEND (byte index 0..3).
- IDLE:
  - On eoc=1 with CH_ENABLE_MASK[channel]=1, latch channel into ch_r and go to DRP_REQ.
  - eoc on a disabled channel is ignored and not counted.
- DRP_REQ (exactly one cycle):
  - drp_den=1, drp_daddr={2'b00, ch_r}.
  - Clear the timeout counter. Go to DRP_WAIT.
- DRP_WAIT:
  - On drp_drdy=1, latch sample=drp_do[15:4] and go to SEND with index 0.
  - If DRP_TIMEOUT cycles elapse without drdy: timeout_count++ (saturates at 8'hFF), go to IDLE, emit nothing, and leave seq unchanged.
  - drp_drdy outside DRP_WAIT is ignored.
- Frame bytes:
  - B0 = SYNC_BYTE
  - B1 = {3'b000, ch_r}
  - B2 = {seq[3:0], sample[11:8]}
  - B3 = sample[7:0]
- SEND handshake:
  - m_tvalid=1 and m_tdata=B[index].
  - A byte transfers on any cycle with m_tvalid && m_tready.
  - After a transfer, index increments and the next byte is presented the following cycle with no bubble required; bubbles are allowed but not required.
  - m_tdata and m_tvalid are stable while m_tvalid=1 and m_tready=0. m_tvalid never drops before its transfer.
  - After B3 transfers: seq increments (4-bit, wraps 15->0), m_tvalid=0, go to IDLE.
  - Minimum frame-to-frame gap is 1 cycle in IDLE.
- Busy drops:
  - An enabled-channel eoc seen in any state other than IDLE increments drop_count, saturating at 16'hFFFF.
  - The same rule applies on the cycle of B3's transfer, since the block returns to IDLE only on the next cycle.
- Registered outputs: m_tdata, m_tvalid, drp_den and drp_daddr are registered; there are no combinational paths from inputs to outputs.
- Unhandled values: an unhandled state encoding returns to IDLE.

Test Plan:
- Basic frame: eoc with channel=0x14, drdy 3 cycles after den with drp_do=16'hABC0, m_tready=1 constantly -> drp_den pulses 1 cycle with daddr=7'h14; bytes A5,14,0A,BC in 4 consecutive cycles; seq becomes 1.
- Backpressure: same stimulus with m_tready toggling 0/1 every cycle, then held low 10 cycles mid-frame -> data stable while stalled, exactly 4 transfers, byte order unchanged.
- Filtering and drops: eoc on channel 0x03 -> no den and drop_count unchanged; second eoc on 0x1C during SEND -> drop_count=1 and only one frame emitted.
- DRP timeout: eoc on 0x14 with drdy never asserted -> return to IDLE after 64 wait cycles, timeout_count=1, no m_tvalid; the next eoc is serviced normally with seq still 0.
- Sequence wrap: 17 back-to-back serviced frames -> high nibble of B2 runs 0..F then 0.
- Reset mid-frame: assert rst after B1 transfers -> m_tvalid=0 next cycle; after release, a new eoc yields a full frame starting with A5 and seq=0.
